cgra0_out_packer_fifo: RTL and testbench
========================================

Name: cgra0_out_packer_fifo

Overview:
- Sits directly downstream of each output PE. Consumes that PE's fifo_data/fifo_we stream and packs pairs of 32-bit results into 64-bit words.
- Buffers the packed words in a FIFO and presents them to the host/DMA side with a valid/ready handshake.
- Produces almost_full. The accelerator controller uses it to drop the global en before the PE pipeline can overrun the buffer.

Parameters:
- DATA_WIDTH, 32, width of one PE result word.
- OUT_WIDTH, 64, packed output width; fixed at 2*DATA_WIDTH.
- DEPTH, 16, FIFO depth in packed words; power of two.
- AF_MARGIN, 4, free entries remaining when almost_full asserts; covers the en-to-fifo_we pipeline latency.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  PE fifo_we; one result word per cycle.
- wr_data  in  DATA_WIDTH  PE fifo_data.
- flush  in  1  single-cycle request to emit any partial pair.
- rd_ready  in  1  consumer accepts the head word.
- rd_valid  out  1  head word available.
- rd_data  out  OUT_WIDTH  head word; low half is the older result.
- rd_strb  out  2  lane valid bits; 2'b11 for full pairs, 2'b01 for a flushed partial.
- almost_full  out  1  count >= DEPTH-AF_MARGIN.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  packed words stored.
- flush_done  out  1  one-cycle pulse when the flush completes.
- overflow  out  1  sticky flag: a packed word was dropped.

Behaviour:
- Reset values:
  - count=0; rd_valid=0; full=0; almost_full=0; overflow=0; flush_done=0.
  - rd_data and rd_strb are don't-care while rd_valid=0.
  - Pointers are 0, the pack holding register is empty, FSM is in IDLE.
  - Reset mid-operation discards all stored and partial data.
- Packer, one holding register plus a half flag:
  - wr_en while half=0: store wr_data, set half=1.
  - wr_en while half=1: push {wr_data, held} with strb 2'b11, then clear half.
- FIFO is first-word-fall-through:
  - rd_valid = (count != 0).
  - rd_data and rd_strb are read combinationally from mem[rd_ptr].
  - A word pushed at edge N is visible with rd_valid=1 after edge N.
  - A pop occurs when rd_valid & rd_ready.
- Push and pop in the same cycle: both are allowed even when full; count is unchanged.
- Push when full with no pop:
  - The packed word is dropped and overflow is set; only rst clears overflow.
  - half is still cleared, so subsequent pairing stays aligned.
- Pointers wrap modulo DEPTH.
- count, full and almost_full are registered and reflect state after the edge.
- Flush FSM, states IDLE and FLUSH:
  - IDLE, flush=1: any same-cycle wr_en is processed first.
    - If half=0 afterwards: pulse flush_done next cycle and stay in IDLE.
    - Otherwise: go to FLUSH.
  - FLUSH: push {0, held} with strb 2'b01 as soon as a slot is free (not full, or pop in the same cycle). Then clear half, pulse flush_done and return to IDLE.
  - wr_en while in FLUSH: the word is held off (not stored) and overflow is set. The controller must keep en low while flushing.
  - flush while in FLUSH: ignored.
- almost_full threshold arithmetic is unsigned. AF_MARGIN=0 makes almost_full equal to full.

Decomposition:
- Shared package holds:
  - OUT_STRB_FULL = 2'b11 and OUT_STRB_HALF = 2'b01.
  - The flush FSM state enum {IDLE, FLUSH}.
  - The CNT_W function $clog2(DEPTH)+1.
- One natural sub-module: cgra0_sync_fifo.
  - Parameterised width and depth, FWFT, combinational read.
  - Reports count, full and almost_full.
  - Storage is OUT_WIDTH+2 wide (data plus strb).
- The packer register and flush FSM live in the top module.

Test Plan:
- Reset, then write 0x11, 0x22 on consecutive cycles with rd_ready=0 -> one cycle after the second write: rd_valid=1, rd_data=0x00000022_00000011, rd_strb=2'b11, count=1.
- Write 3 words 0xA, 0xB, 0xC, then pulse flush -> two entries: 0x0000000B_0000000A with strb 11, then 0x00000000_0000000C with strb 01; flush_done pulses once.
- Keep rd_ready=0 and write 32 words (DEPTH=16) -> almost_full rises at count=12, full at count=16, overflow=0. Write 2 more -> overflow=1, count stays 16, the stored head is unchanged.
- Full FIFO, rd_ready=1 and a completing write in the same cycle -> count stays 16, no overflow, new word lands at the tail, head advances.
- Full FIFO, half=1, flush -> FSM holds in FLUSH with no flush_done. Pop one word -> partial pushed next cycle, strb=01, flush_done pulses.
- Assert rst with count=5 and half=1 -> after the edge: count=0, rd_valid=0, overflow=0. The next single write plus flush yields only that word, with strb 01.

Source files
------------

// File: rtl/cgra0_out_packer_fifo_pkg.sv
// Shared definitions for the CGRA output packer FIFO slice.
//   OUT_STRB_FULL / OUT_STRB_HALF : lane-valid codes stored with each packed word
//   flush_state_e                 : flush FSM states
//   cnt_w()                       : width of an occupancy counter for a given depth
package cgra0_out_packer_fifo_pkg;

  localparam logic [1:0] OUT_STRB_FULL = 2'b11;
  localparam logic [1:0] OUT_STRB_HALF = 2'b01;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Counter must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cgra0_out_packer_fifo_if.sv
// Bus between an output PE / host-DMA side and the packer FIFO.
//   master : drives the PE write stream, flush and rd_ready; observes status
//   slave  : the packer FIFO itself
interface cgra0_out_packer_fifo_if
  import cgra0_out_packer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 64,
  parameter int DEPTH      = 16
) ();

  localparam int CNT_W = cnt_w(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  flush;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [OUT_WIDTH-1:0]  rd_data;
  logic [1:0]            rd_strb;
  logic                  almost_full;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  flush_done;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, flush, rd_ready,
    input  rd_valid, rd_data, rd_strb, almost_full, full, count, flush_done, overflow
  );

  modport slave (
    input  wr_en, wr_data, flush, rd_ready,
    output rd_valid, rd_data, rd_strb, almost_full, full, count, flush_done, overflow
  );

endinterface

// File: rtl/cgra0_sync_fifo.sv
// First-word-fall-through synchronous FIFO with combinational read.
//   push/push_data : write request; dropped when full unless popping this cycle
//   pop            : consumer ready; takes effect only when not empty
//   pop_data       : mem[rd_ptr], valid whenever count != 0
//   count/full/almost_full : registered, reflect occupancy after the edge
module cgra0_sync_fifo
  import cgra0_out_packer_fifo_pkg::*;
#(
  parameter int WIDTH     = 66,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  localparam int CNT_W    = cnt_w(DEPTH),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             almost_full
);

  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);
  // Unsigned threshold; AF_MARGIN=0 collapses it onto FULL_LEVEL.
  localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & (~full | do_pop);

  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_d = count;
    if (do_push && !do_pop)      count_d = count + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count - CNT_W'(1);
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
  // the natural rollover the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count_d;
      full        <= (count_d == FULL_LEVEL);
      almost_full <= (count_d >= AF_LEVEL);
    end
  end

  // NOTE: storage has no reset; contents are only observable once count != 0,
  // and leaving it out lets the array map onto plain RAM/flops without a reset net.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cgra0_out_packer_fifo.sv
// Packs pairs of 32-bit PE results into 64-bit words and buffers them in a
// FWFT FIFO for the host/DMA side.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of cgra0_out_packer_fifo_if (PE write stream, flush,
//              valid/ready read port, strobes, occupancy, flush_done, overflow)
// A flush emits any held odd result as a half word (strb 01); almost_full lets
// the controller drop en before the PE pipeline overruns the buffer.
module cgra0_out_packer_fifo
  import cgra0_out_packer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 4
) (
  input logic clk,
  input logic rst,
  cgra0_out_packer_fifo_if.slave bus
);

  localparam int WORD_W = OUT_WIDTH + 2;
  localparam int CNT_W  = cnt_w(DEPTH);

  flush_state_e          state_q, state_d;
  logic                  half_q, half_d;
  logic [DATA_WIDTH-1:0] held_q, held_d;
  logic                  overflow_q, ovf_set;
  logic                  flush_done_q, done_d;

  logic                  push;
  logic [WORD_W-1:0]     push_word;
  logic [WORD_W-1:0]     head_word;
  logic                  pop;
  logic                  slot_free;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_af;

  assign pop       = (fifo_count != '0) & bus.rd_ready;
  // A slot exists if not full, or if the head leaves in this same cycle.
  assign slot_free = ~fifo_full | pop;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this combinational and latch-free.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    held_d    = held_q;
    done_d    = 1'b0;
    ovf_set   = 1'b0;
    push      = 1'b0;
    push_word = '0;

    case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          if (!half_q) begin
            held_d = bus.wr_data;
            half_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_word = {OUT_STRB_FULL, bus.wr_data, held_q};
            // Pair is consumed even if dropped so later pairing stays aligned.
            half_d    = 1'b0;
            if (!slot_free) ovf_set = 1'b1;
          end
        end
        // Flush sees the result of any same-cycle write.
        if (bus.flush) begin
          if (!half_d) done_d  = 1'b1;
          else         state_d = FLUSH;
        end
      end

      FLUSH: begin
        // Writes are not accepted here; the controller should hold en low.
        if (bus.wr_en) ovf_set = 1'b1;
        if (slot_free) begin
          push      = 1'b1;
          push_word = {OUT_STRB_HALF, {DATA_WIDTH{1'b0}}, held_q};
          half_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      half_q       <= 1'b0;
      held_q       <= '0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      held_q       <= held_d;
      flush_done_q <= done_d;
      if (ovf_set) overflow_q <= 1'b1;
    end
  end

  cgra0_sync_fifo #(
    .WIDTH     (WORD_W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (push_word),
    .pop         (bus.rd_ready),
    .pop_data    (head_word),
    .count       (fifo_count),
    .full        (fifo_full),
    .almost_full (fifo_af)
  );

  assign bus.rd_valid    = (fifo_count != '0);
  assign bus.rd_data     = head_word[OUT_WIDTH-1:0];
  assign bus.rd_strb     = head_word[WORD_W-1:OUT_WIDTH];
  assign bus.count       = fifo_count;
  assign bus.full        = fifo_full;
  assign bus.almost_full = fifo_af;
  assign bus.flush_done  = flush_done_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_cgra0_out_packer_fifo.sv
// Directed self-checking bench for cgra0_out_packer_fifo (DEPTH=16, AF_MARGIN=4).
module tb_cgra0_out_packer_fifo;
  import cgra0_out_packer_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int OW    = 64;
  localparam int DEPTH = 16;
  localparam int AFM   = 4;

  logic clk;
  logic rst;

  cgra0_out_packer_fifo_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH)) bus ();

  cgra0_out_packer_fifo #(
    .DATA_WIDTH (DW),
    .OUT_WIDTH  (OW),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AFM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  function automatic logic [63:0] pair(input logic [31:0] hi, input logic [31:0] lo);
    return {hi, lo};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt;
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.flush    = 1'b0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_af", 64'(bus.almost_full), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_fdone", 64'(bus.flush_done), 64'd0);

    // Basic pair
    wr(32'h11);
    check("pair_wait_valid", 64'(bus.rd_valid), 64'd0);
    wr(32'h22);
    check("pair_valid", 64'(bus.rd_valid), 64'd1);
    check("pair_data", bus.rd_data, 64'h00000022_00000011);
    check("pair_strb", 64'(bus.rd_strb), 64'(OUT_STRB_FULL));
    check("pair_count", 64'(bus.count), 64'd1);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("pair_drained", 64'(bus.count), 64'd0);

    // Three words then flush
    wr(32'hA);
    wr(32'hB);
    wr(32'hC);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_enter_no_done", 64'(bus.flush_done), 64'd0);
    tick();
    check("fl_done", 64'(bus.flush_done), 64'd1);
    check("fl_count", 64'(bus.count), 64'd2);
    check("fl_head0", bus.rd_data, 64'h0000000B_0000000A);
    check("fl_strb0", 64'(bus.rd_strb), 64'b11);
    tick();
    check("fl_done_once", 64'(bus.flush_done), 64'd0);
    bus.rd_ready = 1'b1;
    tick();
    check("fl_head1", bus.rd_data, 64'h00000000_0000000C);
    check("fl_strb1", 64'(bus.rd_strb), 64'b01);
    tick();
    bus.rd_ready = 1'b0;
    check("fl_drained", 64'(bus.count), 64'd0);

    // Fill: 32 words -> 16 entries
    for (int i = 0; i < 32; i++) begin
      wr(32'(i + 1));
      exp_cnt = (i + 1) / 2;
      check($sformatf("fill_count_%0d", i), 64'(bus.count), 64'(exp_cnt));
      check($sformatf("fill_af_%0d", i), 64'(bus.almost_full), 64'(exp_cnt >= 12));
      check($sformatf("fill_full_%0d", i), 64'(bus.full), 64'(exp_cnt == 16));
    end
    check("fill_ovf", 64'(bus.overflow), 64'd0);
    check("fill_head", bus.rd_data, pair(32'd2, 32'd1));
    wr(32'd33);
    wr(32'd34);
    check("drop_ovf", 64'(bus.overflow), 64'd1);
    check("drop_count", 64'(bus.count), 64'd16);
    check("drop_head", bus.rd_data, pair(32'd2, 32'd1));

    // Push and pop together while full
    wr(32'd35);
    bus.rd_ready = 1'b1;
    wr(32'd36);
    bus.rd_ready = 1'b0;
    check("pp_count", 64'(bus.count), 64'd16);
    check("pp_full", 64'(bus.full), 64'd1);
    check("pp_head", bus.rd_data, pair(32'd4, 32'd3));

    // Flush while full: stalls until a pop frees a slot
    wr(32'd37);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("ff_no_done0", 64'(bus.flush_done), 64'd0);
    tick();
    check("ff_no_done1", 64'(bus.flush_done), 64'd0);
    check("ff_count_hold", 64'(bus.count), 64'd16);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("ff_done", 64'(bus.flush_done), 64'd1);
    check("ff_count", 64'(bus.count), 64'd16);
    tick();
    check("ff_done_once", 64'(bus.flush_done), 64'd0);

    // Drain and verify order, including the same-cycle tail word and the partial
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      check($sformatf("drain_%0d", i), bus.rd_data, pair(32'(2 * i + 6), 32'(2 * i + 5)));
      tick();
    end
    check("drain_pp_tail", bus.rd_data, pair(32'd36, 32'd35));
    check("drain_pp_strb", 64'(bus.rd_strb), 64'b11);
    tick();
    check("drain_partial", bus.rd_data, pair(32'd0, 32'd37));
    check("drain_partial_strb", 64'(bus.rd_strb), 64'b01);
    tick();
    bus.rd_ready = 1'b0;
    check("drain_empty", 64'(bus.rd_valid), 64'd0);

    // Flush with nothing held: pulse next cycle, no push
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("eflush_done", 64'(bus.flush_done), 64'd1);
    check("eflush_count", 64'(bus.count), 64'd0);

    // Reset mid-operation: count=5, half=1
    for (int i = 0; i < 11; i++) wr(32'(32'h100 + i));
    check("mr_pre_count", 64'(bus.count), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_count", 64'(bus.count), 64'd0);
    check("mr_valid", 64'(bus.rd_valid), 64'd0);
    check("mr_ovf", 64'(bus.overflow), 64'd0);
    wr(32'h99);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    check("mr_done", 64'(bus.flush_done), 64'd1);
    check("mr_count1", 64'(bus.count), 64'd1);
    check("mr_data", bus.rd_data, 64'h00000000_00000099);
    check("mr_strb", 64'(bus.rd_strb), 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
